// File: rtl/stepper_pkg.sv
// Shared encodings for the stepper command sequencer: FSM states, direction codes, counter widths.
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int DEB_W    = 20;
  localparam int DEAD_W   = 23;
  localparam int TRAVEL_W = 30;

  // Moore decode of the state register onto the driver's direction code.
  function automatic logic [1:0] dir_of(input state_t s);
    case (s)
      ST_UP:   dir_of = DIR_UP;
      ST_DOWN: dir_of = DIR_DOWN;
      default: dir_of = DIR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a counter debouncer; the output follows the synced input
// only after CYCLES consecutive samples that differ from the current output.
module input_debouncer
  import stepper_pkg::*;
#(
  parameter int   CYCLES    = 500_000,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic [1:0]       sync_q;
  logic [DEB_W-1:0] cnt;

  // Sync flops reset to RESET_VAL so a released reset never looks like an input change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RESET_VAL}};
      cnt    <= '0;
      level  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(CYCLES - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stepper_cmd_sequencer.sv
// Button/limit front end and motion FSM for the stepper driver, with reversal dead time.
// Optional travel-timeout fault is enabled by defining STEPPER_TIMEOUT_EN.
module stepper_cmd_sequencer
  import stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REVERSE_DEAD    = 5_000_000,
  parameter int TRAVEL_TIMEOUT  = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  input  logic       lim_up_n,
  input  logic       lim_down_n,
  output logic [1:0] switch_pos,
  output logic       stop_Up,
  output logic       stop_Down,
  output logic [2:0] state_o,
  output logic       fault
);

  logic up_lvl, down_lvl, stop_lvl;
  logic up_q, down_q, stop_q;
  logic up_p, down_p, stop_p;

  input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb_up
    (.clk(clk), .rst(rst), .raw(btn_up), .level(up_lvl));
  input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb_down
    (.clk(clk), .rst(rst), .raw(btn_down), .level(down_lvl));
  input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_deb_stop
    (.clk(clk), .rst(rst), .raw(btn_stop), .level(stop_lvl));
  input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_lim_up
    (.clk(clk), .rst(rst), .raw(lim_up_n), .level(stop_Up));
  input_debouncer #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_deb_lim_down
    (.clk(clk), .rst(rst), .raw(lim_down_n), .level(stop_Down));

  // Registered rising-edge detect: one-cycle press pulses, held buttons do not repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {up_q, down_q, stop_q} <= '0;
      {up_p, down_p, stop_p} <= '0;
    end else begin
      {up_q, down_q, stop_q} <= {up_lvl, down_lvl, stop_lvl};
      up_p   <= up_lvl & ~up_q;
      down_p <= down_lvl & ~down_q;
      stop_p <= stop_lvl & ~stop_q;
    end
  end

  state_t              state, next_state;
  state_t              pending, next_pending;
  logic [DEAD_W-1:0]   dead_cnt;
  logic                timeout;

`ifdef STEPPER_TIMEOUT_EN
  logic [TRAVEL_W-1:0] travel_cnt;
  logic                travel_entry;

  assign travel_entry = (next_state != state) && ((next_state == ST_UP) || (next_state == ST_DOWN));
  assign timeout      = (travel_cnt == TRAVEL_W'(TRAVEL_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      travel_cnt <= '0;
    end else if (travel_entry) begin
      travel_cnt <= '0;
    end else if (((state == ST_UP) || (state == ST_DOWN)) && (travel_cnt != '1)) begin
      travel_cnt <= travel_cnt + 1'b1;
    end
  end

  assign fault = (state == ST_FAULT);
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= ST_IDLE;
      dead_cnt <= '0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
      if ((state != ST_DEAD) && (next_state == ST_DEAD)) dead_cnt <= '0;
      else if (state == ST_DEAD)                         dead_cnt <= dead_cnt + 1'b1;
    end
  end

  // Limit checks come before reversal presses so an arriving limit always wins.
  always_comb begin
    next_state   = state;
    next_pending = pending;
    case (state)
      ST_IDLE: begin
        if (!stop_p) begin
          if (up_p) begin
            if (stop_Up) next_state = ST_UP;
          end else if (down_p && stop_Down) begin
            next_state = ST_DOWN;
          end
        end
      end
      ST_UP: begin
        if (!stop_Up || stop_p) next_state = ST_IDLE;
        else if (down_p) begin
          next_state   = ST_DEAD;
          next_pending = ST_DOWN;
        end else if (timeout) next_state = ST_FAULT;
      end
      ST_DOWN: begin
        if (!stop_Down || stop_p) next_state = ST_IDLE;
        else if (up_p) begin
          next_state   = ST_DEAD;
          next_pending = ST_UP;
        end else if (timeout) next_state = ST_FAULT;
      end
      ST_DEAD: begin
        if (stop_p) next_state = ST_IDLE;
        else begin
          if (up_p)        next_pending = ST_UP;
          else if (down_p) next_pending = ST_DOWN;
          if (dead_cnt == DEAD_W'(REVERSE_DEAD - 1)) begin
            if (next_pending == ST_UP) next_state = stop_Up ? ST_UP : ST_IDLE;
            else                       next_state = stop_Down ? ST_DOWN : ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        if (stop_p) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign switch_pos = dir_of(state);
  assign state_o    = state;

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// Directed bench for stepper_cmd_sequencer with short debounce/dead/timeout parameters.
module tb_stepper_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_stop, lim_up_n, lim_down_n;
  logic [1:0] switch_pos;
  logic       stop_Up, stop_Down, fault;
  logic [2:0] state_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic saw_down;

  stepper_cmd_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .REVERSE_DEAD(8),
    .TRAVEL_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_stop(btn_stop),
    .lim_up_n(lim_up_n), .lim_down_n(lim_down_n),
    .switch_pos(switch_pos), .stop_Up(stop_Up), .stop_Down(stop_Down),
    .state_o(state_o), .fault(fault)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks: inputs change at posedge+1
  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // mask = {stop, down, up}; FSM reacts 8 edges after the drive, task returns after 14
  task automatic press(input logic [2:0] mask);
    btn_up   = mask[0];
    btn_down = mask[1];
    btn_stop = mask[2];
    idle_wait(6);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_stop = 1'b0;
    idle_wait(8);
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_stop = 1'b0;
    lim_up_n = 1'b1; lim_down_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_switch_pos", switch_pos, 2'b00);
    check("rst_state", state_o, 3'd0);
    check("rst_fault", fault, 1'b0);
    check("rst_stop_up", stop_Up, 1'b1);
    check("rst_stop_down", stop_Down, 1'b1);
    settle();
    rst = 1'b0;
    idle_wait(2);

    // short glitch on up: never debounced
    btn_up = 1'b1;
    idle_wait(3);
    btn_up = 1'b0;
    idle_wait(12);
    @(negedge clk);
    check("glitch_state", state_o, 3'd0);
    settle();

    // press latency: 2 + 4 + 1 + 1 edges
    btn_up = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("lat_e7_pos", switch_pos, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("lat_e8_pos", switch_pos, 2'b01);
    check("lat_e8_state", state_o, 3'd1);
    repeat (2) @(posedge clk);
    #1 btn_up = 1'b0;
    idle_wait(10);

    // top limit while moving up
    lim_up_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lim_e5_stop_up", stop_Up, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("lim_e6_stop_up", stop_Up, 1'b0);
    check("lim_e6_state", state_o, 3'd1);
    @(posedge clk);
    @(negedge clk);
    check("lim_e7_state", state_o, 3'd0);
    check("lim_e7_pos", switch_pos, 2'b00);
    settle();
    press(3'b001);
    @(negedge clk);
    check("up_at_limit_state", state_o, 3'd0);
    settle();
    lim_up_n = 1'b1;
    idle_wait(10);
    @(negedge clk);
    check("lim_release_stop_up", stop_Up, 1'b1);
    settle();

    // reversal up -> dead (8 cycles) -> down
    press(3'b001);
    btn_down = 1'b1;
    idle_wait(6);
    btn_down = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rev_e7_state", state_o, 3'd1);
    @(posedge clk);
    @(negedge clk);
    check("rev_e8_state", state_o, 3'd3);
    check("rev_e8_pos", switch_pos, 2'b00);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("rev_e15_state", state_o, 3'd3);
    check("rev_e15_pos", switch_pos, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("rev_e16_state", state_o, 3'd2);
    check("rev_e16_pos", switch_pos, 2'b10);
    settle();
    idle_wait(10);

    // bottom limit while moving down
    lim_down_n = 1'b0;
    idle_wait(8);
    @(negedge clk);
    check("lim_dn_stop_down", stop_Down, 1'b0);
    check("lim_dn_state", state_o, 3'd0);
    settle();
    lim_down_n = 1'b1;
    idle_wait(10);

    // stop during dead time: motor never drives down
    press(3'b001);
    saw_down = 1'b0;
    for (int c = 0; c < 30; c++) begin
      btn_down = (c < 6);
      btn_stop = (c >= 2) && (c < 8);
      @(negedge clk);
      if (switch_pos == 2'b10) saw_down = 1'b1;
      if (c == 8)  check("dead_stop_c8_state", state_o, 3'd3);
      if (c == 10) check("dead_stop_c10_state", state_o, 3'd0);
      @(posedge clk);
      #1;
    end
    check("dead_stop_no_down", saw_down, 1'b0);

    // same-cycle presses
    press(3'b101);
    @(negedge clk);
    check("stop_up_same_state", state_o, 3'd0);
    settle();
    press(3'b011);
    @(negedge clk);
    check("up_down_same_state", state_o, 3'd1);
    check("up_down_same_pos", switch_pos, 2'b01);
    settle();

`ifdef STEPPER_TIMEOUT_EN
    press(3'b100);
    btn_up = 1'b1;
    idle_wait(6);
    btn_up = 1'b0;
    repeat (65) @(posedge clk);
    @(negedge clk);
    check("to_e71_state", state_o, 3'd1);
    @(posedge clk);
    @(negedge clk);
    check("to_e72_state", state_o, 3'd4);
    check("to_e72_fault", fault, 1'b1);
    check("to_e72_pos", switch_pos, 2'b00);
    settle();
    press(3'b100);
    @(negedge clk);
    check("to_stop_state", state_o, 3'd0);
    check("to_stop_fault", fault, 1'b0);
    settle();
`else
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("no_to_fault", fault, 1'b0);
    check("no_to_state", state_o, 3'd1);
    settle();
    press(3'b100);
    @(negedge clk);
    check("no_to_stop_state", state_o, 3'd0);
    settle();
`endif

    // asynchronous reset mid-UP with the top limit just debounced
    press(3'b001);
    lim_up_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("arst_pre_stop_up", stop_Up, 1'b0);
    check("arst_pre_state", state_o, 3'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_state", state_o, 3'd0);
    check("arst_pos", switch_pos, 2'b00);
    check("arst_stop_up", stop_Up, 1'b1);
    check("arst_fault", fault, 1'b0);
    lim_up_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_wait(2);
    @(negedge clk);
    check("arst_after_state", state_o, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
